// File: rtl/ccsds123_sample_assembler.sv
// Packs a little-endian byte stream into AXI-Stream beats of PIPELINES samples.
// Counts samples per image and flags the final beat with tlast and frame_done.
module ccsds123_sample_assembler #(
    parameter int D         = 16,
    parameter int PIPELINES = 2,
    parameter int NX        = 16,
    parameter int NY        = 16,
    parameter int NZ        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [PIPELINES*D-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   frame_done
);

    localparam int N  = NX * NY * NZ;
    localparam int NB = 2 * PIPELINES;
    localparam int BW = $clog2(NB);
    localparam int SW = $clog2(N + 1);
    localparam int OW = PIPELINES * D;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   bidx;
    logic [SW-1:0]   scnt;
    logic [7:0]      lo_byte;
    logic [OW-1:0]   asm_reg;
    logic [OW-1:0]   asm_next;
    logic [15:0]     sample_word;
    logic            hold_last;
    logic            ready_reg;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;

    logic            accept;
    logic            final_byte;
    logic            beat_done;
    logic            out_free;
    logic            load_fill;
    logic            load_hold;
    logic            go_hold;

    assign s_axis_tready = ready_reg;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    assign frame_done    = out_valid && m_axis_tready && out_last;

    assign accept      = s_axis_tvalid && ready_reg;
    assign sample_word = {s_axis_tdata, lo_byte};
    assign final_byte  = accept && bidx[0] && (scnt == SW'(N - 1));
    assign beat_done   = accept && ((bidx == BW'(NB - 1)) || final_byte);
    assign out_free    = !out_valid || m_axis_tready;

    // Assembly register with the current odd byte merged into its lane,
    // so a completing byte can go straight to the output register.
    always_comb begin
        asm_next = asm_reg;
        for (int i = 0; i < PIPELINES; i++) begin
            if (bidx == BW'(2 * i + 1)) begin
                asm_next[i*D +: D] = sample_word[D-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_fill  = 1'b0;
        load_hold  = 1'b0;
        go_hold    = 1'b0;
        case (state)
            FILL: begin
                if (beat_done) begin
                    if (out_free) begin
                        load_fill = 1'b1;
                    end else begin
                        go_hold    = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    load_hold  = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Byte index, sample counter and assembly storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_reg <= 1'b0;
            bidx      <= '0;
            scnt      <= '0;
            lo_byte   <= '0;
            asm_reg   <= '0;
            hold_last <= 1'b0;
        end else begin
            ready_reg <= (state_next == FILL);
            if (accept) begin
                if (beat_done) begin
                    bidx <= '0;
                end else begin
                    bidx <= bidx + BW'(1);
                end
                if (!bidx[0]) begin
                    lo_byte <= s_axis_tdata;
                end
                if (bidx[0]) begin
                    scnt <= (final_byte && load_fill) ? '0 : scnt + SW'(1);
                end
            end
            if (load_hold && hold_last) begin
                scnt <= '0;
            end
            if (load_fill || load_hold) begin
                asm_reg <= '0;
            end else if (accept) begin
                asm_reg <= asm_next;
            end
            if (go_hold) begin
                hold_last <= final_byte;
            end
        end
    end

    // Output register; data and last only change on a load, so they stay
    // stable while a beat waits for m_axis_tready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_fill) begin
            out_data  <= asm_next;
            out_valid <= 1'b1;
            out_last  <= final_byte;
        end else if (load_hold) begin
            out_data  <= asm_reg;
            out_valid <= 1'b1;
            out_last  <= hold_last;
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ccsds123_sample_assembler.sv
// Randomized scoreboard bench for ccsds123_sample_assembler: a sample-level
// reference model predicts each beat, a monitor checks beats as they leave.
module tb_ccsds123_sample_assembler;

    localparam int D  = 12;
    localparam int P  = 3;
    localparam int NX = 7;
    localparam int NY = 1;
    localparam int NZ = 1;
    localparam int N  = NX * NY * NZ;
    localparam int OW = P * D;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [7:0]    s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    beat_t         exp_q[$];
    logic [D-1:0]  cur_lanes[$];
    int            img_samples = 0;
    logic          have_lo = 1'b0;
    logic [7:0]    lo_hold = 8'h00;

    int            ready_mode = 0;
    int            stall_cnt = 0;

    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;

    ccsds123_sample_assembler #(
        .D(D), .PIPELINES(P), .NX(NX), .NY(NY), .NZ(NZ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .frame_done    (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // m_tready changes just after the rising edge so it is stable at the
    // falling edge where the monitor samples.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: bytes pair into samples, samples group into beats of
    // P lanes, and every N samples closes an image.
    task automatic model_byte(input logic [7:0] b);
        beat_t bt;
        logic [15:0] word;
        if (!have_lo) begin
            lo_hold = b;
            have_lo = 1'b1;
        end else begin
            have_lo = 1'b0;
            word = {b, lo_hold};
            cur_lanes.push_back(word[D-1:0]);
            img_samples++;
            if (cur_lanes.size() == P || img_samples == N) begin
                bt.data = '0;
                for (int i = 0; i < cur_lanes.size(); i++) begin
                    bt.data[i*D +: D] = cur_lanes[i];
                end
                bt.last = (img_samples == N);
                exp_q.push_back(bt);
                cur_lanes.delete();
                if (img_samples == N) img_samples = 0;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_lanes.delete();
        img_samples = 0;
        have_lo = 1'b0;
    endtask

    // Called at a falling edge; s_tready is constant between rising edges,
    // so its value here decides acceptance at the next rising edge.
    task automatic apply_stimulus(input logic [7:0] b);
        int waited = 0;
        s_tvalid = 1'b1;
        s_tdata  = b;
        while (!s_tready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited > 0) stall_cnt++;
        if (!s_tready) begin
            total++;
            bad++;
            $display("[TB] FAIL input_timeout: got s_tready=0 expected 1 at %0t", $time);
        end else begin
            model_byte(b);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check_val(name, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_output_reset(input string tag);
        check_val({tag, "_s_tready"}, s_tready, 0);
        check_val({tag, "_m_tvalid"}, m_tvalid, 0);
        check_val({tag, "_m_tdata"}, m_tdata, 0);
        check_val({tag, "_m_tlast"}, m_tlast, 0);
        check_val({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Scoreboard monitor: pops an expected beat on every output handshake
    // and also checks that a stalled beat does not change.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", m_tvalid, 1);
                check_val("stall_data", m_tdata, prev_data);
                check_val("stall_last", m_tlast, prev_last);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat: got %0h expected none at %0t", m_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_val("beat_data", m_tdata, e.data);
                    check_val("beat_last", m_tlast, e.last);
                    check_val("frame_done", frame_done, e.last);
                end
            end else begin
                check_val("frame_done_idle", frame_done, 0);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    initial begin
        int gap;
        reset      = 1'b1;
        s_tvalid   = 1'b0;
        s_tdata    = 8'h00;
        m_tready   = 1'b0;
        ready_mode = 0;

        repeat (2) @(negedge clk);
        check_output_reset("reset");
        reset = 1'b0;
        @(negedge clk);
        check_val("ready_after_reset", s_tready, 1);

        $display("[TB] backpressure with width truncation");
        apply_stimulus(8'hFF);
        apply_stimulus(8'hFF);
        for (int i = 3; i <= 4 * P; i++) apply_stimulus(8'(i * 17));
        repeat (10) @(negedge clk);
        check_val("bp_s_tready", s_tready, 0);
        check_val("bp_m_tvalid", m_tvalid, 1);
        check_val("bp_data_first", m_tdata[D-1:0], 12'hFFF);
        ready_mode = 1;
        drain("bp_drain");

        $display("[TB] randomized traffic");
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            gap = $urandom_range(0, 3);
            if (gap == 3) repeat ($urandom_range(1, 2)) @(negedge clk);
            apply_stimulus(8'($urandom));
        end
        ready_mode = 1;
        drain("random_drain");

        $display("[TB] full-rate back-to-back images");
        stall_cnt = 0;
        for (int i = 0; i < 4 * N; i++) apply_stimulus(8'($urandom));
        check_val("no_input_stall", stall_cnt, 0);
        drain("stream_drain");

        $display("[TB] reset mid-image");
        for (int i = 0; i < 3; i++) apply_stimulus(8'(8'hA0 + i));
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_output_reset("midreset");
        reset = 1'b0;
        @(negedge clk);
        check_val("ready_after_midreset", s_tready, 1);
        for (int i = 0; i < 2 * N; i++) apply_stimulus(8'(8'h30 + i));
        drain("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
